// File: rtl/instr_encoder_loader.sv
// Turns field-level RV32I requests into 32-bit instruction words and writes them
// sequentially into instruction memory, holding the core until the program is loaded.
module instr_encoder_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_fmt,
  input  logic [6:0]    req_op,
  input  logic [2:0]    req_funct3,
  input  logic          req_funct7b5,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [31:0]   req_imm,
  input  logic          req_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   word_count,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state_o
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only while waiting in LOAD and nothing is buffered otherwise.

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_ENC  = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  state_t        state_q, state_d;
  logic [2:0]    fmt_q;
  logic [6:0]    op_q;
  logic [2:0]    f3_q;
  logic          f7b5_q;
  logic [4:0]    rd_q, rs1_q, rs2_q;
  logic [31:0]   imm_q;
  logic          last_q;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   count_q, count_d;

  logic          accept;
  logic          bad_req;
  logic [31:0]   enc_word;
  logic [6:0]    f7;
  logic [11:0]   i_field;

  assign accept = req_valid && (state_q == S_LOAD);

  always_comb begin
    f7       = {1'b0, f7b5_q, 5'b0};
    i_field  = imm_q[11:0];
    // Immediate shifts carry funct7 in the upper immediate bits.
    if (op_q == 7'b0010011 && (f3_q == 3'b001 || f3_q == 3'b101))
      i_field = {f7[6:5], 5'b0, imm_q[4:0]};
    enc_word = 32'd0;
    bad_req  = 1'b0;
    case (fmt_q)
      FMT_R: enc_word = {f7, rs2_q, rs1_q, f3_q, rd_q, op_q};
      FMT_I: enc_word = {i_field, rs1_q, f3_q, rd_q, op_q};
      FMT_S: enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
      FMT_B: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
        bad_req  = imm_q[0];
      end
      FMT_U: enc_word = {imm_q[31:12], rd_q, op_q};
      FMT_J: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        bad_req  = imm_q[0];
      end
      default: bad_req = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    count_d = count_q;
    case (state_q)
      S_LOAD: if (accept) state_d = S_ENC;
      S_ENC: begin
        if (bad_req) begin
          state_d = S_ERR;
        end else begin
          wdata_d = enc_word;
          state_d = S_WR;
        end
      end
      S_WR: begin
        count_d = count_q + 1'b1;
        // The last address is still written; only a further word would overflow.
        if (last_q)
          state_d = S_DONE;
        else if (count_q[AW-1:0] == AW'(DEPTH - 1))
          state_d = S_ERR;
        else
          state_d = S_LOAD;
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      wdata_q <= 32'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fmt_q  <= 3'd0;
      op_q   <= 7'd0;
      f3_q   <= 3'd0;
      f7b5_q <= 1'b0;
      rd_q   <= 5'd0;
      rs1_q  <= 5'd0;
      rs2_q  <= 5'd0;
      imm_q  <= 32'd0;
      last_q <= 1'b0;
    end else if (accept) begin
      fmt_q  <= req_fmt;
      op_q   <= req_op;
      f3_q   <= req_funct3;
      f7b5_q <= req_funct7b5;
      rd_q   <= req_rd;
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
      imm_q  <= req_imm;
      last_q <= req_last;
    end
  end

  assign req_ready   = (state_q == S_LOAD);
  assign imem_we     = (state_q == S_WR);
  assign imem_addr   = count_q[AW-1:0];
  assign imem_wdata  = wdata_q;
  assign word_count  = count_q;
  assign cpu_hold    = (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader: requests are scored against an
// arithmetic RV32I encoding model and an expected write queue.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int W     = AW + 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_fmt = '0;
  logic [6:0]    req_op = '0;
  logic [2:0]    req_funct3 = '0;
  logic          req_funct7b5 = 1'b0;
  logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0]   req_imm = '0;
  logic          req_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          cpu_hold, done, err;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int exp_addr = 0;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_op(req_op), .req_funct3(req_funct3),
    .req_funct7b5(req_funct7b5), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .cpu_hold(cpu_hold), .done(done), .err(err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset_n   = 1'b0;
    exp_q.delete();
    exp_addr  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_enc(input int unsigned fmt, op, f3, f7b5, rd, rs1, rs2,
                                          input int unsigned im);
    int unsigned w, field;
    case (fmt)
      0: w = (f7b5 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        field = im & 32'hfff;
        if (op == 32'h13 && (f3 == 1 || f3 == 5)) field = (f7b5 << 10) | (im & 31);
        w = (field << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      2: w = (((im >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((im & 31) << 7) | op;
      3: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
             | (f3 << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | op;
      4: w = (im & 32'hfffff000) | (rd << 7) | op;
      5: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20)
             | (((im >> 12) & 255) << 12) | (rd << 7) | op;
      default: w = 0;
    endcase
    return w;
  endfunction

  // ---------------- driver ----------------
  // Waits (bounded) for req_ready, presents one request for a single accepting edge,
  // and returns 1 ns after that edge.
  task automatic send(input int unsigned fmt, op, f3, f7b5, rd, rs1, rs2,
                      input logic [31:0] imm, input bit last,
                      input logic [31:0] exp_word, input bit legal);
    int budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      check("ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_fmt = fmt[2:0]; req_op = op[6:0]; req_funct3 = f3[2:0]; req_funct7b5 = f7b5[0];
    req_rd = rd[4:0]; req_rs1 = rs1[4:0]; req_rs2 = rs2[4:0];
    req_imm = imm; req_last = last; req_valid = 1'b1;
    if (legal) begin
      exp_q.push_back({exp_addr[AW-1:0], exp_word});
      exp_addr++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_imm   = $urandom;
    req_fmt   = 3'($urandom_range(0, 7));
  endtask

  task automatic send_rand(input bit last);
    int unsigned fmt, op, f3, f7b5, rd, rs1, rs2;
    logic [31:0] imm;
    fmt  = $urandom_range(0, 5);
    op   = $urandom_range(0, 127);
    if (fmt == 1 && $urandom_range(0, 1) == 1) op = 32'h13;
    f3   = $urandom_range(0, 7);
    f7b5 = $urandom_range(0, 1);
    rd   = $urandom_range(0, 31);
    rs1  = $urandom_range(0, 31);
    rs2  = $urandom_range(0, 31);
    imm  = $urandom;
    if (fmt == 3 || fmt == 5) imm[0] = 1'b0;
    send(fmt, op, f3, f7b5, rd, rs1, rs2, imm, last,
         ref_enc(fmt, op, f3, f7b5, rd, rs1, rs2, imm), 1'b1);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'(imem_wdata), 64'hdead_0000);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e[W-1:32]));
        check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    do_reset();
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // addi x1,x0,5 with cycle-exact latency
    send(1, 32'h13, 0, 0, 1, 0, 0, 32'd5, 1'b0, 32'h00500093, 1'b1);
    check("lat_we_k", 64'(imem_we), 64'd0);
    @(posedge clk); #1;
    check("lat_we_k1", 64'(imem_we), 64'd1);
    check("lat_addr", 64'(imem_addr), 64'd0);
    check("lat_data", 64'(imem_wdata), 64'h00500093);
    @(posedge clk); #1;
    check("lat_we_k2", 64'(imem_we), 64'd0);
    check("lat_count", 64'(word_count), 64'd1);
    drain("drain_addi");

    // Directed vectors, ending with last
    do_reset();
    send(0, 32'h33, 0, 0, 3, 1, 2, 32'd0, 1'b0, 32'h002081B3, 1'b1);
    send(2, 32'h23, 2, 0, 0, 1, 2, 32'd8, 1'b0, 32'h0020A423, 1'b1);
    drain("drain_rs");
    check("count_2", 64'(word_count), 64'd2);
    send(3, 32'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3, 1'b1);
    send(5, 32'h6F, 0, 0, 1, 0, 0, 32'd8, 1'b0, 32'h008000EF, 1'b1);
    send(4, 32'h37, 0, 0, 5, 0, 0, 32'h12345000, 1'b0, 32'h123452B7, 1'b1);
    send(1, 32'h13, 5, 1, 1, 1, 0, 32'd3, 1'b1, 32'h4030D093, 1'b1);
    drain("drain_vec");
    check("done_done", 64'(done), 64'd1);
    check("done_hold", 64'(cpu_hold), 64'd0);
    check("done_ready", 64'(req_ready), 64'd0);
    check("done_err", 64'(err), 64'd0);
    req_valid = 1'b1;
    repeat (6) @(negedge clk);
    req_valid = 1'b0;
    check("done_count", 64'(word_count), 64'd6);
    check("done_stays", 64'(done), 64'd1);

    // Randomized program, last on the final word
    do_reset();
    for (int i = 0; i < 30; i++) send_rand(i == 29);
    drain("drain_rand");
    check("rand_count", 64'(word_count), 64'd30);
    check("rand_done", 64'(done), 64'd1);

    // Illegal format
    do_reset();
    send(6, 32'h33, 0, 0, 1, 1, 1, 32'd0, 1'b0, 32'd0, 1'b0);
    drain("drain_fmt6");
    check("fmt6_err", 64'(err), 64'd1);
    check("fmt6_hold", 64'(cpu_hold), 64'd1);
    check("fmt6_ready", 64'(req_ready), 64'd0);
    check("fmt6_done", 64'(done), 64'd0);
    check("fmt6_count", 64'(word_count), 64'd0);

    // Odd branch offset after one good word
    do_reset();
    send_rand(1'b0);
    send(3, 32'h63, 0, 0, 0, 1, 2, 32'd3, 1'b0, 32'd0, 1'b0);
    drain("drain_bodd");
    check("bodd_err", 64'(err), 64'd1);
    check("bodd_count", 64'(word_count), 64'd1);

    // Odd jump offset
    do_reset();
    send(5, 32'h6F, 0, 0, 1, 0, 0, 32'd9, 1'b0, 32'd0, 1'b0);
    drain("drain_jodd");
    check("jodd_err", 64'(err), 64'd1);

    // Overflow: DEPTH words without last
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_rand(1'b0);
    drain("drain_ovf");
    check("ovf_count", 64'(word_count), 64'(DEPTH));
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_hold", 64'(cpu_hold), 64'd1);
    check("ovf_done", 64'(done), 64'd0);
    check("ovf_ready", 64'(req_ready), 64'd0);

    // Reset while encoding
    do_reset();
    send_rand(1'b0);
    reset_n = 1'b0;
    exp_q.delete();
    exp_addr = 0;
    #1;
    check("mid_enc_we", 64'(imem_we), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while writing
    send_rand(1'b0);
    @(posedge clk); #1;
    check("mid_wr_we_hi", 64'(imem_we), 64'd1);
    reset_n = 1'b0;
    exp_q.delete();
    exp_addr = 0;
    #1;
    check("mid_wr_we_lo", 64'(imem_we), 64'd0);
    check("mid_wr_count", 64'(word_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(1, 32'h13, 0, 0, 1, 0, 0, 32'd5, 1'b0, 32'h00500093, 1'b1);
    drain("drain_restart");
    check("restart_count", 64'(word_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
